inv_add_round_key: RTL and testbench

INV_ADD_ROUND_KEY -- requirements
Module: inv_add_round_key

---
 rtl/inv_add_round_key.sv | 84 ++++++++
 tb/tb_inv_add_round_key.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/inv_add_round_key.sv
// inv_add_round_key: inverse-cipher AddRoundKey stage with round-key store and
// a two-entry (output register + skid) elastic output path.
module inv_add_round_key #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_we,
    input  logic [3:0]   key_idx,
    input  logic [127:0] key_in,
    output logic         keys_ready,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [3:0]   in_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic [3:0]   out_round,
    output logic         out_mix_en,
    output logic         err_round
);
    logic [127:0] keys [0:NR];
    logic [NR:0]  mask, mask_nxt;
    logic         sk_valid, sk_nxt, sk_mix;
    logic [127:0] sk_state;
    logic [3:0]   sk_round;
    logic         key_ok, legal, acc, take, adv, mix;
    logic [127:0] beat;

    always_comb begin
        key_ok = key_we && 32'(key_idx) <= NR;
        legal  = 32'(in_round) <= NR;
        acc    = in_valid && in_ready;
        take   = acc && legal;
        adv    = !out_valid || out_ready;
        mix    = in_round != 4'd0 && 32'(in_round) < NR;
        // the array holds pre-edge contents, so a same-edge key write is not seen
        beat   = in_state ^ (legal ? keys[in_round] : 128'd0);
        sk_nxt = adv ? sk_valid && take : sk_valid || take;
        mask_nxt = mask;
        if (key_ok)
            mask_nxt[key_idx] = 1'b1;
    end

    // key contents survive reset; the cleared mask makes them unusable
    always_ff @(posedge clk)
        if (key_ok)
            keys[key_idx] <= key_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask       <= '0;
            keys_ready <= 1'b0;
            in_ready   <= 1'b0;
            err_round  <= 1'b0;
            out_valid  <= 1'b0;
            out_state  <= '0;
            out_round  <= '0;
            out_mix_en <= 1'b0;
            sk_valid   <= 1'b0;
            sk_state   <= '0;
            sk_round   <= '0;
            sk_mix     <= 1'b0;
        end else begin
            mask       <= mask_nxt;
            keys_ready <= &mask_nxt;
            in_ready   <= keys_ready && !sk_nxt;
            err_round  <= acc && !legal;
            sk_valid   <= sk_nxt;
            if (adv) begin
                out_valid  <= sk_valid || take;
                out_state  <= sk_valid ? sk_state : beat;
                out_round  <= sk_valid ? sk_round : in_round;
                out_mix_en <= sk_valid ? sk_mix : mix;
            end
            if (take && (sk_valid || !adv)) begin
                sk_state <= beat;
                sk_round <= in_round;
                sk_mix   <= mix;
            end
        end
    end
endmodule

// File: tb/tb_inv_add_round_key.sv
// tb_inv_add_round_key: directed vectors for the AddRoundKey stage.
module tb_inv_add_round_key;
    logic         clk = 0, rst_n = 0, key_we = 0, in_valid = 0, out_ready = 1;
    logic [3:0]   key_idx = 0, in_round = 0;
    logic [127:0] key_in = 0, in_state = 0;
    logic         keys_ready, in_ready, out_valid, out_mix_en, err_round;
    logic [127:0] out_state;
    logic [3:0]   out_round;
    int checks = 0, failures = 0;
    localparam logic [127:0] K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] NK  = 128'hffeeddccbbaa99887766554433221100;

    inv_add_round_key #(.NR(10)) dut (
        .clk(clk), .rst_n(rst_n), .key_we(key_we), .key_idx(key_idx), .key_in(key_in),
        .keys_ready(keys_ready), .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .in_round(in_round), .out_valid(out_valid),
        .out_ready(out_ready), .out_state(out_state), .out_round(out_round),
        .out_mix_en(out_mix_en), .err_round(err_round)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] key_of(int i);
        logic [7:0] b = 8'(i);
        return i == 10 ? K10 : 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0 ^ {16{b}};
    endfunction

    function automatic logic [127:0] st_of(int r);
        logic [7:0] b = 8'(r * 17);
        return 128'hdeadbeef0123456789abcdef55aa33cc ^ {16{b}};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int r, input logic [127:0] s);
        in_valid = 1;
        in_round = 4'(r);
        in_state = s;
    endtask

    initial begin
        tick();
        tick();
        check("rst_keys_ready", 128'(keys_ready), 0);
        check("rst_in_ready", 128'(in_ready), 0);
        check("rst_out_valid", 128'(out_valid), 0);
        check("rst_err", 128'(err_round), 0);
        check("rst_out_state", out_state, 0);
        rst_n = 1;
        key_we = 1;
        for (int i = 0; i < 10; i++) begin
            key_idx = 4'(i);
            key_in = key_of(i);
            tick();
        end
        key_idx = 4'd12;
        key_in = '1;
        tick();
        check("partial_keys_ready", 128'(keys_ready), 0);
        check("partial_in_ready", 128'(in_ready), 0);
        key_idx = 4'd10;
        key_in = K10;
        tick();
        key_we = 0;
        check("last_key_keys_ready", 128'(keys_ready), 1);
        check("last_key_in_ready_lag", 128'(in_ready), 0);
        tick();
        check("in_ready_up", 128'(in_ready), 1);

        beat(10, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        tick();
        check("r10_valid", 128'(out_valid), 1);
        check("r10_state", out_state, 128'h7ad5fda789ef4e272bca100b3d9ff59f);
        check("r10_round", 128'(out_round), 10);
        check("r10_mix", 128'(out_mix_en), 0);

        for (int r = 9; r >= 0; r--) begin
            beat(r, st_of(r));
            tick();
            check($sformatf("stream%0d_valid", r), 128'(out_valid), 1);
            check($sformatf("stream%0d_state", r), out_state, st_of(r) ^ key_of(r));
            check($sformatf("stream%0d_mix", r), 128'(out_mix_en), r != 0);
        end
        in_valid = 0;
        tick();
        check("drained", 128'(out_valid), 0);

        out_ready = 0;
        beat(3, st_of(3));
        tick();
        beat(4, st_of(4));
        tick();
        check("bp_in_ready", 128'(in_ready), 0);
        check("bp_hold1", out_state, st_of(3) ^ key_of(3));
        beat(5, st_of(5));
        tick();
        check("bp_hold2", out_state, st_of(3) ^ key_of(3));
        check("bp_hold_round", 128'(out_round), 3);
        check("bp_in_ready2", 128'(in_ready), 0);
        in_valid = 0;
        out_ready = 1;
        tick();
        check("bp_first_pop", out_state, st_of(4) ^ key_of(4));
        check("bp_valid", 128'(out_valid), 1);
        check("bp_ready_back", 128'(in_ready), 1);
        tick();
        check("bp_empty", 128'(out_valid), 0);

        beat(12, st_of(1));
        tick();
        in_valid = 0;
        check("err_pulse", 128'(err_round), 1);
        check("err_no_out", 128'(out_valid), 0);
        tick();
        check("err_clear", 128'(err_round), 0);
        check("err_no_out2", 128'(out_valid), 0);

        beat(2, st_of(2));
        key_we = 1;
        key_idx = 4'd2;
        key_in = NK;
        tick();
        check("rbw_old_key", out_state, st_of(2) ^ key_of(2));
        beat(4, st_of(4));
        key_idx = 4'd5;
        tick();
        key_we = 0;
        check("par_write_beat", out_state, st_of(4) ^ key_of(4));
        beat(2, st_of(2));
        tick();
        check("rbw_new_key", out_state, st_of(2) ^ NK);
        beat(5, st_of(5));
        tick();
        check("par_new_key", out_state, st_of(5) ^ NK);

        out_ready = 0;
        beat(6, st_of(6));
        tick();
        beat(7, st_of(7));
        tick();
        in_valid = 0;
        rst_n = 0;
        tick();
        check("mid_rst_valid", 128'(out_valid), 0);
        check("mid_rst_keys_ready", 128'(keys_ready), 0);
        check("mid_rst_in_ready", 128'(in_ready), 0);
        rst_n = 1;
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_rst_no_beat%0d", i), 128'(out_valid), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
